// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory block-fill path.
// The instruction cache uses the same width constants.
package imem_pkg;
    localparam int IMEM_ADDR_WIDTH  = 6;
    localparam int IMEM_BLOCK_WIDTH = 128;
    localparam int IMEM_WORD_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RELEASE = 2'b10
    } imem_state_e;
endpackage

// File: rtl/imem_block_responder_if.sv
// Block-fill handshake between the instruction cache (master) and instruction memory (slave).
interface imem_block_responder_if;
    logic                                  mem_read;
    logic [imem_pkg::IMEM_ADDR_WIDTH-1:0]  mem_address;
    logic                                  mem_busywait;
    logic [imem_pkg::IMEM_BLOCK_WIDTH-1:0] mem_readdata;

    modport master (output mem_read, mem_address, input  mem_busywait, mem_readdata);
    modport slave  (input  mem_read, mem_address, output mem_busywait, mem_readdata);
endinterface

// File: rtl/imem_block_array.sv
// Block storage with a word-granular write port and a combinational block read.
// A write landing on the block being read shows up in the same cycle's read data.
module imem_block_array
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = IMEM_ADDR_WIDTH,
    parameter int BLOCK_WIDTH = IMEM_BLOCK_WIDTH,
    parameter int BLOCK_COUNT = 64
) (
    input  logic                       clock,
    input  logic                       wr_en_i,
    input  logic [ADDR_WIDTH+1:0]      wr_addr_i,
    input  logic [IMEM_WORD_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
    output logic [BLOCK_WIDTH-1:0]     rd_data_o
);
    localparam int IDX_W = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;

    logic [BLOCK_WIDTH-1:0] mem_q [BLOCK_COUNT];

    logic [ADDR_WIDTH-1:0] wr_blk;
    logic [1:0]            wr_word;
    logic [6:0]            wr_lsb;
    logic                  wr_ok, rd_ok;

    assign wr_blk  = wr_addr_i[ADDR_WIDTH+1:2];
    assign wr_word = wr_addr_i[1:0];
    assign wr_lsb  = {wr_word, 5'd0};
    assign wr_ok   = wr_en_i && ({1'b0, wr_blk} < (ADDR_WIDTH+1)'(BLOCK_COUNT));
    assign rd_ok   = {1'b0, rd_addr_i} < (ADDR_WIDTH+1)'(BLOCK_COUNT);

    // No reset: contents survive a responder reset so a preloaded program is kept.
    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[wr_blk[IDX_W-1:0]][wr_lsb +: IMEM_WORD_WIDTH] <= wr_data_i;
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_ok) begin
            rd_data_o = mem_q[rd_addr_i[IDX_W-1:0]];
            if (wr_ok && (wr_blk == rd_addr_i)) rd_data_o[wr_lsb +: IMEM_WORD_WIDTH] = wr_data_i;
        end
    end
endmodule

// File: rtl/imem_block_responder.sv
// Instruction-memory side of the cache block fill: holds busywait for READ_LATENCY
// cycles, then returns the latched block and waits for the cache to drop mem_read.
module imem_block_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH   = IMEM_ADDR_WIDTH,
    parameter int BLOCK_WIDTH  = IMEM_BLOCK_WIDTH,
    parameter int BLOCK_COUNT  = 64,
    parameter int READ_LATENCY = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    imem_block_responder_if.slave      mem,
    input  logic                       load_en,
    input  logic [ADDR_WIDTH+1:0]      load_addr,
    input  logic [IMEM_WORD_WIDTH-1:0] load_data
);
    imem_state_e            state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   busy_q, busy_d;
    logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
    logic [BLOCK_WIDTH-1:0] blk_data;

    imem_block_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_WIDTH(BLOCK_WIDTH),
        .BLOCK_COUNT(BLOCK_COUNT)
    ) u_array (
        .clock    (clock),
        .wr_en_i  (load_en),
        .wr_addr_i(load_addr),
        .wr_data_i(load_data),
        .rd_addr_i(addr_q),
        .rd_data_o(blk_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem.mem_read) begin
                    addr_d  = mem.mem_address;
                    cnt_d   = 8'(READ_LATENCY - 1);
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rdata_d = blk_data;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            // Hold off a new fill until the cache has visibly left its read state.
            RELEASE: begin
                if (!mem.mem_read) state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem.mem_busywait = busy_q;
    assign mem.mem_readdata = rdata_q;
endmodule

// File: tb/tb_imem_block_responder.sv
// Directed bench: per-cycle vector table on the default responder, then hand sequences
// for reset abort, single-cycle latency and out-of-range blocks.
module tb_imem_block_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    imem_block_responder_if b0();
    imem_block_responder_if b1();
    imem_block_responder_if b2();

    imem_block_responder dut0 (.clock(clock), .reset(reset), .mem(b0.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
    imem_block_responder #(.READ_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .mem(b1.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
    imem_block_responder #(.BLOCK_COUNT(32)) dut2 (.clock(clock), .reset(reset), .mem(b2.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    always #5 clock = ~clock;

    localparam logic [127:0] ALL = '1;
    localparam logic [127:0] D5  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D7M = {64'hFFFFFFFF_FFFFFFFF, 64'h0};
    localparam logic [127:0] D7  = {32'h0BADF00D, 32'hCAFEF00D, 64'h0};
    localparam logic [127:0] W0M = {96'h0, 32'hFFFFFFFF};

    typedef struct {
        logic         rd;
        logic [5:0]   addr;
        logic         ld;
        logic [7:0]   la;
        logic [31:0]  ldd;
        logic         bw;
        logic [127:0] mask;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t v(logic rd, logic [5:0] addr, logic ld, logic [7:0] la,
                               logic [31:0] ldd, logic bw, logic [127:0] mask, logic [127:0] exp);
        vec_t r;
        r.rd = rd; r.addr = addr; r.ld = ld; r.la = la; r.ldd = ldd;
        r.bw = bw; r.mask = mask; r.exp = exp;
        return r;
    endfunction

    function automatic logic bw(int w);
        case (w)
            0:       return b0.mem_busywait;
            1:       return b1.mem_busywait;
            default: return b2.mem_busywait;
        endcase
    endfunction

    function automatic logic [127:0] dat(int w);
        case (w)
            0:       return b0.mem_readdata;
            1:       return b1.mem_readdata;
            default: return b2.mem_readdata;
        endcase
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller has already raised mem_read; counts busywait-high cycles of one pulse.
    task automatic measure(input int w, output int hi, output logic first);
        hi = 0;
        first = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) first = bw(w);
            if (bw(w)) hi++;
            else if (hi > 0) break;
        end
    endtask

    initial begin
        int   hi;
        logic first;

        b0.mem_read = 1'b0; b0.mem_address = '0;
        b1.mem_read = 1'b0; b1.mem_address = '0;
        b2.mem_read = 1'b0; b2.mem_address = '0;

        tick(); tick();
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("reset_bw%0d", w), 128'(bw(w)), 128'd0);
            chk($sformatf("reset_data%0d", w), dat(w), 128'd0);
        end
        reset = 1'b1;

        tbl.push_back(v(0, 6'h00, 1, 8'h14, 32'h11111111, 0, ALL, 0));
        tbl.push_back(v(0, 6'h00, 1, 8'h15, 32'h22222222, 0, ALL, 0));
        tbl.push_back(v(0, 6'h00, 1, 8'h16, 32'h33333333, 0, ALL, 0));
        tbl.push_back(v(0, 6'h00, 1, 8'h17, 32'h44444444, 0, ALL, 0));
        tbl.push_back(v(0, 6'h00, 1, 8'h00, 32'hDEADBEEF, 0, ALL, 0));
        tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 1, ALL, 0));
        tbl.push_back(v(1, 6'h3F, 0, 8'h00, 32'h0, 1, ALL, 0));
        tbl.push_back(v(0, 6'h00, 0, 8'h00, 32'h0, 1, ALL, 0));
        tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 1, ALL, 0));
        tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 1, ALL, 0));
        tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 0, ALL, D5));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 0, ALL, D5));
        tbl.push_back(v(0, 6'h05, 0, 8'h00, 32'h0, 0, ALL, D5));
        for (int i = 0; i < 5; i++) tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 1, ALL, D5));
        tbl.push_back(v(1, 6'h05, 0, 8'h00, 32'h0, 0, ALL, D5));
        tbl.push_back(v(0, 6'h00, 0, 8'h00, 32'h0, 0, ALL, D5));
        tbl.push_back(v(1, 6'h07, 0, 8'h00, 32'h0, 1, ALL, D5));
        tbl.push_back(v(1, 6'h07, 0, 8'h00, 32'h0, 1, ALL, D5));
        tbl.push_back(v(1, 6'h07, 1, 8'h1E, 32'hCAFEF00D, 1, ALL, D5));
        tbl.push_back(v(1, 6'h07, 0, 8'h00, 32'h0, 1, ALL, D5));
        tbl.push_back(v(1, 6'h07, 0, 8'h00, 32'h0, 1, ALL, D5));
        tbl.push_back(v(1, 6'h07, 1, 8'h1F, 32'h0BADF00D, 0, D7M, D7));
        tbl.push_back(v(0, 6'h00, 0, 8'h00, 32'h0, 0, D7M, D7));
        tbl.push_back(v(0, 6'h00, 0, 8'h00, 32'h0, 0, D7M, D7));

        foreach (tbl[i]) begin
            b0.mem_read    = tbl[i].rd;
            b0.mem_address = tbl[i].addr;
            load_en        = tbl[i].ld;
            load_addr      = tbl[i].la;
            load_data      = tbl[i].ldd;
            tick();
            chk($sformatf("row%0d_bw", i), 128'(b0.mem_busywait), 128'(tbl[i].bw));
            chk($sformatf("row%0d_data", i), b0.mem_readdata & tbl[i].mask, tbl[i].exp);
        end
        load_en = 1'b0;

        // Reset in the third BUSY cycle aborts the read.
        b0.mem_read = 1'b1; b0.mem_address = 6'h02;
        tick(); tick(); tick();
        chk("abort_pre_bw", 128'(b0.mem_busywait), 128'd1);
        reset = 1'b0;
        #1;
        chk("abort_bw", 128'(b0.mem_busywait), 128'd0);
        chk("abort_data", b0.mem_readdata, 128'd0);
        tick(); tick();
        chk("abort_hold_bw", 128'(b0.mem_busywait), 128'd0);
        b0.mem_read = 1'b0;
        reset = 1'b1;
        tick();
        b0.mem_read = 1'b1; b0.mem_address = 6'h05;
        measure(0, hi, first);
        chk("post_reset_first", 128'(first), 128'd1);
        chk("post_reset_len", 128'(hi), 128'd5);
        chk("post_reset_data", b0.mem_readdata, D5);
        b0.mem_read = 1'b0;
        tick();

        // Single-cycle latency.
        b1.mem_read = 1'b1; b1.mem_address = 6'h00;
        measure(1, hi, first);
        chk("lat1_first", 128'(first), 128'd1);
        chk("lat1_len", 128'(hi), 128'd1);
        chk("lat1_word0", b1.mem_readdata & W0M, 128'hDEADBEEF);
        b1.mem_read = 1'b0;
        tick();

        // Smaller array: in-range block, then out-of-range block returns zero.
        b2.mem_read = 1'b1; b2.mem_address = 6'h05;
        measure(2, hi, first);
        chk("bc32_in_len", 128'(hi), 128'd5);
        chk("bc32_in_data", b2.mem_readdata, D5);
        b2.mem_read = 1'b0;
        tick();
        b2.mem_read = 1'b1; b2.mem_address = 6'h25;
        measure(2, hi, first);
        chk("bc32_oor_first", 128'(first), 128'd1);
        chk("bc32_oor_len", 128'(hi), 128'd5);
        chk("bc32_oor_data", b2.mem_readdata, 128'd0);
        b2.mem_read = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
